regfile_sb: RTL and testbench

Parametrised multi-port register file with write-back/link write ports, same-cycle write bypass and a per-register pending-write scoreboard. It sits between decode and the execute stage of the pipelined core: decode reads operands and busy flags, issue marks destinations pending, and write-back retires them. It replaces negedge-write register storage with posedge writes plus bypass, so reads in the write cycle return the new value.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/sb_counter.sv | 29 ++
 rtl/regfile_sb.sv | 89 ++++++++
 tb/tb_regfile_sb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizing, architectural register constants and read-port packing helper
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREGS  = 32;
    localparam int ZERO_REG   = 0;
    localparam int LINK_REG   = 31;

    function automatic int portLsb(input int port, input int width);
        return port * width;
    endfunction
endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating pending-write counter, one issue increment and two retire decrements
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec0,
    input  logic             dec1,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             unf
);
    logic [CNT_W+1:0] sum;
    logic [CNT_W-1:0] cntNext;

    // top bit of sum is the sign; bit CNT_W alone means one past max
    always_comb begin
        sum     = {2'b00, cnt} + (CNT_W+2)'(inc) - (CNT_W+2)'(dec0) - (CNT_W+2)'(dec1);
        unf     = !flush && sum[CNT_W+1];
        ovf     = !flush && !sum[CNT_W+1] && sum[CNT_W];
        cntNext = (flush || unf) ? '0 : ovf ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else        cnt <= cntNext;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read register file with write-back/link ports, same-cycle bypass
// and a per-register pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic                     sb_overflow,
    output logic                     sb_underflow
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  cnt  [NREGS];
    logic [NREGS-1:0]  wr0Hit, wr1Hit, issHit, ovfVec, unfVec;
    logic              wr0Act, wr1Act;

    // writes seen while reset is low are dropped, including from the bypass path
    assign wr0Act = wr0_en && rst_n;
    assign wr1Act = wr1_en && rst_n;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            wr0Hit[r] = wr0Act && wr0_addr == ADDR_W'(r) && r != ZERO_REG;
            wr1Hit[r] = wr1Act && wr1_addr == ADDR_W'(r) && r != ZERO_REG;
            issHit[r] = iss_en && iss_addr == ADDR_W'(r) && r != ZERO_REG;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                if (wr1Hit[r])      regs[r] <= wr1_data;
                else if (wr0Hit[r]) regs[r] <= wr0_data;
        end

    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (issHit[r]),
            .dec0  (wr0Hit[r]),
            .dec1  (wr1Hit[r]),
            .flush (flush),
            .cnt   (cnt[r]),
            .ovf   (ovfVec[r]),
            .unf   (unfVec[r])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              ok;
        assign a  = rd_addr[portLsb(i, ADDR_W) +: ADDR_W];
        assign ok = a != ADDR_W'(ZERO_REG) && 32'(a) < NREGS;
        assign rd_data[portLsb(i, DATA_W) +: DATA_W] =
            !ok                         ? '0       :
            (wr1Act && wr1_addr == a)   ? wr1_data :
            (wr0Act && wr0_addr == a)   ? wr0_data : regs[a];
        assign rd_busy[i] = ok && cnt[a] != '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sb_overflow  <= 1'b0;
            sb_underflow <= 1'b0;
        end else begin
            sb_overflow  <= sb_overflow  || (|ovfVec);
            sb_underflow <= sb_underflow || (|unfVec);
        end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenario tasks for regfile_sb with hand-computed expectations
module tb_regfile_sb;
    import regfile_pkg::*;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR*AW-1:0]  rdAddr;
    logic [NR*DW-1:0]  rdData;
    logic [NR-1:0]     rdBusy;
    logic              wr0En, wr1En, issEn, flush;
    logic [AW-1:0]     wr0Addr, wr1Addr, issAddr;
    logic [DW-1:0]     wr0Data, wr1Data;
    logic              sbOverflow, sbUnderflow;
    int                nVec = 0;
    int                nFail = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr      (rdAddr),
        .rd_data      (rdData),
        .rd_busy      (rdBusy),
        .wr0_en       (wr0En),
        .wr0_addr     (wr0Addr),
        .wr0_data     (wr0Data),
        .wr1_en       (wr1En),
        .wr1_addr     (wr1Addr),
        .wr1_data     (wr1Data),
        .iss_en       (issEn),
        .iss_addr     (issAddr),
        .flush        (flush),
        .sb_overflow  (sbOverflow),
        .sb_underflow (sbUnderflow)
    );

    task automatic idle();
        wr0En = 0; wr1En = 0; issEn = 0; flush = 0;
        wr0Addr = 0; wr1Addr = 0; issAddr = 0;
        wr0Data = 0; wr1Data = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setRd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rdAddr = {a1, a0};
    endtask

    task automatic issue(input logic [AW-1:0] a);
        issEn = 1; issAddr = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        for (int a = 0; a < 32; a++) begin
            setRd(AW'(a), AW'(31 - a));
            #1;
            nVec++;
            if (rdData !== '0 || rdBusy !== '0) begin
                nFail++;
                $display("FAIL reset_read a=%0d: got data %h busy %b, expected 0 and 0", a, rdData, rdBusy);
            end
        end
        nVec++;
        if (sbOverflow !== 1'b0 || sbUnderflow !== 1'b0) begin
            nFail++;
            $display("FAIL reset_flags: got ovf %b unf %b, expected 0 0", sbOverflow, sbUnderflow);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_write_bypass();
        setRd(5, 5);
        issue(5);
        nVec++;
        if (rdBusy !== 2'b11) begin
            nFail++;
            $display("FAIL issue_r5_busy: got %b expected 11", rdBusy);
        end
        wr0En = 1; wr0Addr = 5; wr0Data = 32'hDEADBEEF;
        #1;
        nVec++;
        if (rdData[31:0] !== 32'hDEADBEEF || rdBusy[0] !== 1'b1) begin
            nFail++;
            $display("FAIL bypass_r5: got %h busy %b expected deadbeef busy 1", rdData[31:0], rdBusy[0]);
        end
        tick();
        idle();
        #1;
        nVec++;
        if (rdData[31:0] !== 32'hDEADBEEF || rdBusy[0] !== 1'b0) begin
            nFail++;
            $display("FAIL array_r5: got %h busy %b expected deadbeef busy 0", rdData[31:0], rdBusy[0]);
        end
        setRd(0, 5);
        wr0En = 1; wr0Addr = 0; wr0Data = 32'h1234;
        #1;
        nVec++;
        if (rdData[31:0] !== 32'h0) begin
            nFail++;
            $display("FAIL r0_bypass: got %h expected 0", rdData[31:0]);
        end
        tick();
        idle();
        #1;
        nVec++;
        if (rdData !== {32'hDEADBEEF, 32'h0} || sbUnderflow !== 1'b0) begin
            nFail++;
            $display("FAIL r0_array: got %h unf %b expected deadbeef00000000 unf 0", rdData, sbUnderflow);
        end
    endtask

    task automatic test_dual_write();
        setRd(LINK_REG[AW-1:0], LINK_REG[AW-1:0]);
        issue(LINK_REG[AW-1:0]);
        issue(LINK_REG[AW-1:0]);
        wr0En = 1; wr0Addr = 31; wr0Data = 32'h11;
        wr1En = 1; wr1Addr = 31; wr1Data = 32'h00400008;
        #1;
        nVec++;
        if (rdData[63:32] !== 32'h00400008) begin
            nFail++;
            $display("FAIL dual_bypass_r31: got %h expected 00400008", rdData[63:32]);
        end
        tick();
        idle();
        #1;
        nVec++;
        if (rdData[63:32] !== 32'h00400008 || rdBusy !== 2'b00 || sbUnderflow !== 1'b0) begin
            nFail++;
            $display("FAIL dual_array_r31: got %h busy %b unf %b expected 00400008 00 0", rdData[63:32], rdBusy, sbUnderflow);
        end
    endtask

    task automatic test_overflow();
        setRd(7, 7);
        for (int k = 0; k < 3; k++) issue(7);
        nVec++;
        if (rdBusy[0] !== 1'b1 || sbOverflow !== 1'b0) begin
            nFail++;
            $display("FAIL r7_three_issues: got busy %b ovf %b expected 1 0", rdBusy[0], sbOverflow);
        end
        issue(7);
        nVec++;
        if (rdBusy[0] !== 1'b1 || sbOverflow !== 1'b1) begin
            nFail++;
            $display("FAIL r7_overflow: got busy %b ovf %b expected 1 1", rdBusy[0], sbOverflow);
        end
        for (int k = 0; k < 3; k++) begin
            wr0En = 1; wr0Addr = 7; wr0Data = 32'h70 + k;
            #1;
            nVec++;
            if (rdBusy[0] !== 1'b1) begin
                nFail++;
                $display("FAIL r7_busy_during_retire%0d: got %b expected 1", k, rdBusy[0]);
            end
            tick();
            idle();
            nVec++;
            if (rdBusy[0] !== (k < 2)) begin
                nFail++;
                $display("FAIL r7_busy_after_retire%0d: got %b expected %b", k, rdBusy[0], k < 2);
            end
        end
        issue(7);
        issEn = 1; issAddr = 7;
        wr0En = 1; wr0Addr = 7; wr0Data = 32'h77;
        tick();
        idle();
        nVec++;
        if (rdBusy[0] !== 1'b1 || rdData[31:0] !== 32'h77) begin
            nFail++;
            $display("FAIL r7_net_zero: got busy %b data %h expected 1 00000077", rdBusy[0], rdData[31:0]);
        end
        wr0En = 1; wr0Addr = 7; wr0Data = 32'h78;
        tick();
        idle();
        nVec++;
        if (rdBusy[0] !== 1'b0 || sbUnderflow !== 1'b0) begin
            nFail++;
            $display("FAIL r7_final_retire: got busy %b unf %b expected 0 0", rdBusy[0], sbUnderflow);
        end
    endtask

    task automatic test_flush();
        setRd(3, 3);
        issue(3);
        issue(3);
        flush = 1;
        issEn = 1; issAddr = 3;
        wr0En = 1; wr0Addr = 3; wr0Data = 32'hABCD;
        tick();
        idle();
        nVec++;
        if (rdBusy !== 2'b00 || sbUnderflow !== 1'b0 || rdData[31:0] !== 32'hABCD) begin
            nFail++;
            $display("FAIL flush_r3: got busy %b unf %b data %h expected 00 0 0000abcd", rdBusy, sbUnderflow, rdData[31:0]);
        end
        setRd(9, 9);
        wr0En = 1; wr0Addr = 9; wr0Data = 32'h99;
        tick();
        idle();
        nVec++;
        if (sbUnderflow !== 1'b1 || rdData[31:0] !== 32'h99 || rdBusy[0] !== 1'b0) begin
            nFail++;
            $display("FAIL underflow_r9: got unf %b data %h busy %b expected 1 00000099 0", sbUnderflow, rdData[31:0], rdBusy[0]);
        end
    endtask

    task automatic test_back_to_back();
        setRd(4, 4);
        issue(4);
        issue(4);
        wr0En = 1; wr0Addr = 4; wr0Data = 32'h44;
        wr1En = 1; wr1Addr = 4; wr1Data = 32'h55;
        tick();
        idle();
        nVec++;
        if (rdBusy[0] !== 1'b0 || rdData[31:0] !== 32'h55) begin
            nFail++;
            $display("FAIL double_retire_r4: got busy %b data %h expected 0 00000055", rdBusy[0], rdData[31:0]);
        end
        setRd(6, 8);
        wr0En = 1; wr0Addr = 6; wr0Data = 32'hA;
        wr1En = 1; wr1Addr = 8; wr1Data = 32'hB;
        #1;
        nVec++;
        if (rdData !== {32'hB, 32'hA}) begin
            nFail++;
            $display("FAIL split_bypass: got %h expected 0000000b0000000a", rdData);
        end
        tick();
        idle();
        #1;
        nVec++;
        if (rdData !== {32'hB, 32'hA}) begin
            nFail++;
            $display("FAIL split_array: got %h expected 0000000b0000000a", rdData);
        end
    endtask

    task automatic test_reset_mid();
        setRd(10, 5);
        issue(10);
        nVec++;
        if (rdBusy !== 2'b01 || rdData[63:32] !== 32'hDEADBEEF) begin
            nFail++;
            $display("FAIL pre_reset: got busy %b r5 %h expected 01 deadbeef", rdBusy, rdData[63:32]);
        end
        wr0En = 1; wr0Addr = 5; wr0Data = 32'h5555;
        #2;
        rst_n = 0;
        #1;
        nVec++;
        if (rdData !== '0 || rdBusy !== '0 || sbOverflow !== 1'b0 || sbUnderflow !== 1'b0) begin
            nFail++;
            $display("FAIL mid_reset: got data %h busy %b ovf %b unf %b expected 0 00 0 0", rdData, rdBusy, sbOverflow, sbUnderflow);
        end
        tick();
        rst_n = 1;
        idle();
        #1;
        nVec++;
        if (rdData !== '0 || rdBusy !== '0) begin
            nFail++;
            $display("FAIL after_reset_r5: got data %h busy %b expected 0 00", rdData, rdBusy);
        end
    endtask

    initial begin
        idle();
        rdAddr = '0;
        test_reset();
        test_write_bypass();
        test_dual_write();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
